// File: rtl/wb_seq.sv
// wb_seq: register-file write-back sequencer for the multicycle MIPS datapath.
// Drives the write-register select, write-data select and write enable for
// single-write ops (R-type, I-type, jal, push) and the two-write pop.
// Optional feature macro: WB_SEQ_ERR_EN (err pulse on illegal op_class 6/7).
// Outputs are Moore decodes of the state register and latched class. hold
// gates reg_write/done combinationally, so a stall suppresses the write in the
// same cycle. An asynchronous reset clears the state immediately.
module wb_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op_class,
  input  logic       mem_ready,
  input  logic       hold,
  output logic [1:0] wreg_sel,
  output logic [1:0] wdata_sel,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CLS_W = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [CLS_W-1:0] OP_NONE  = 3'd0;
  localparam logic [CLS_W-1:0] OP_RTYPE = 3'd1;
  localparam logic [CLS_W-1:0] OP_ITYPE = 3'd2;
  localparam logic [CLS_W-1:0] OP_JAL   = 3'd3;
  localparam logic [CLS_W-1:0] OP_PUSH  = 3'd4;
  localparam logic [CLS_W-1:0] OP_POP   = 3'd5;

  // Write-register mux codes
  localparam logic [SEL_W-1:0] WREG_RT   = 2'b00;
  localparam logic [SEL_W-1:0] WREG_SP   = 2'b01;
  localparam logic [SEL_W-1:0] WREG_RA   = 2'b10;
  localparam logic [SEL_W-1:0] WREG_RD   = 2'b11;

  // Write-data mux codes
  localparam logic [SEL_W-1:0] WDATA_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WDATA_MEM = 2'b01;
  localparam logic [SEL_W-1:0] WDATA_PC4 = 2'b10;
  localparam logic [SEL_W-1:0] WDATA_SP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR1      = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_WR2      = 3'd3,
    ST_FIN      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CLS_W-1:0] cls_q, cls_d;

  // State and latched class register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cls_q   <= OP_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state and Moore output decode; hold freezes state and gates write/done
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wreg_sel  = WREG_RT;
    wdata_sel = WDATA_ALU;
    reg_write = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cls_d = op_class;
          unique case (op_class)
            OP_RTYPE, OP_ITYPE, OP_JAL, OP_PUSH: state_d = ST_WR1;
            OP_POP:                              state_d = ST_WAIT_MEM;
            default:                             state_d = ST_FIN;
          endcase
        end
      end

      ST_WR1: begin
        reg_write = 1'b1;
        unique case (cls_q)
          OP_RTYPE: begin wreg_sel = WREG_RD; wdata_sel = WDATA_ALU; end
          OP_ITYPE: begin wreg_sel = WREG_RT; wdata_sel = WDATA_ALU; end
          OP_JAL:   begin wreg_sel = WREG_RA; wdata_sel = WDATA_PC4; end
          OP_PUSH:  begin wreg_sel = WREG_SP; wdata_sel = WDATA_SP;  end
          OP_POP:   begin wreg_sel = WREG_RT; wdata_sel = WDATA_MEM; end
          default:  begin wreg_sel = WREG_RT; wdata_sel = WDATA_ALU; end
        endcase
        // pop's first write (rt from memory) is not the last one
        if (cls_q == OP_POP) begin
          state_d = ST_WR2;
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_MEM: begin
        if (mem_ready) state_d = ST_WR1;
      end

      ST_WR2: begin
        wreg_sel  = WREG_SP;
        wdata_sel = WDATA_SP;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // stall: keep selects, suppress side effects, freeze everything
    if (hold) begin
      state_d   = state_q;
      cls_d     = cls_q;
      reg_write = 1'b0;
      done      = 1'b0;
    end
  end

`ifdef WB_SEQ_ERR_EN
  // Illegal class flag, coincident with the FIN done pulse
  always_comb begin
    err = 1'b0;
    if (state_q == ST_FIN && cls_q[2:1] == 2'b11 && !hold) err = 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
